// File: rtl/booth_if.sv
// Operand/result bundle for booth_serial_multiplier.
// The master drives the start strobe and operands; the slave returns busy, valid and the product.
interface booth_if #(
  parameter int WIDTH = 9
);
  logic                 en;
  logic                 signed_mode;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 valid;
  logic [2*WIDTH-1:0]   S;

  modport master (output en, signed_mode, A, B, input busy, valid, S);
  modport slave  (input en, signed_mode, A, B, output busy, valid, S);
endinterface

// File: rtl/booth_serial_multiplier.sv
// Iterative signed/unsigned Booth multiplier, one recoding step per cycle.
// Define BOOTH_RADIX4_EN for the radix-4 datapath; the default build is radix-2.
module booth_serial_multiplier #(
  parameter int WIDTH = 9
) (
  input  logic    clk,
  input  logic    rst_n,
  booth_if.slave  bus
);
  // One guard bit lets one signed core cover both signed and unsigned operands.
  localparam int N = WIDTH + 1;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER  = (N + 1) / 2;
  localparam int MUL_W = 2 * ITER;
  localparam int ACC_W = N + 2;
`else
  localparam int ITER  = N;
  localparam int MUL_W = N;
  localparam int ACC_W = N + 1;
`endif
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     accept;
  logic signed [ACC_W-1:0]  mcand;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic signed [ACC_W-1:0]  pp, sum;
  logic [MUL_W-1:0]         mul, mul_nxt;
  logic                     q, q_nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     valid_q;
  logic [PW-1:0]            s_q;
  logic [N-1:0]             a_ext, b_ext;

  assign a_ext = {bus.signed_mode & bus.A[WIDTH-1], bus.A};
  assign b_ext = {bus.signed_mode & bus.B[WIDTH-1], bus.B};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: if (bus.en) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: begin
        if (bus.en) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Booth recoding of the low multiplier bits plus the bit shifted out last step.
  always_comb begin
    pp = '0;
`ifdef BOOTH_RADIX4_EN
    case ({mul[1:0], q})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand <<< 1;
      3'b100:         pp = -(mcand <<< 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    sum = acc + pp;
    {acc_nxt, mul_nxt, q_nxt} = {{2{sum[ACC_W-1]}}, sum, mul[MUL_W-1:1]};
`else
    case ({mul[0], q})
      2'b01:   pp = mcand;
      2'b10:   pp = -mcand;
      default: pp = '0;
    endcase
    sum = acc + pp;
    {acc_nxt, mul_nxt, q_nxt} = {sum[ACC_W-1], sum, mul};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mul     <= '0;
      q       <= 1'b0;
      cnt     <= '0;
      valid_q <= 1'b0;
      s_q     <= '0;
    end else begin
      valid_q <= (state == DONE);
      // The shifted {acc,mul} pair holds the full product; only the low 2*WIDTH bits are meaningful.
      if (state == DONE) s_q <= PW'({acc, mul});
      if (accept) begin
        mcand <= ACC_W'($signed(a_ext));
        acc   <= '0;
        mul   <= MUL_W'($signed(b_ext));
        q     <= 1'b0;
        cnt   <= CNT_W'(ITER);
      end else if (state == CALC) begin
        acc <= acc_nxt;
        mul <= mul_nxt;
        q   <= q_nxt;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.busy  = (state == CALC);
  assign bus.valid = valid_q;
  assign bus.S     = s_q;

endmodule
